// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front end with a one-cycle cache read port and a 1-entry skid buffer.
// Define BRANCH_DELAY_SLOT_EN to deliver the in-flight instruction on a redirect instead of squashing it.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iCacheReadAddr,
    input  logic [31:0] iCacheReadData,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectAddr,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPC
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    typedef enum logic {RUN, HOLD} FetchState;

    FetchState   state;
    logic [31:0] pcReg;
    logic        pend;
    logic [31:0] pendPC;
    logic        skidValid;
    logic [31:0] skidInstr;
    logic [31:0] skidPC;
    logic        squash;

    assign squash         = redirectValid && !DELAY_SLOT;
    assign iCacheReadAddr = pcReg;

    // The PC path and the output/skid path are updated independently; a redirect
    // only overrides the PC path unless the in-flight instruction is squashed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pcReg      <= RESET_PC;
            pend       <= 1'b0;
            pendPC     <= 32'h0;
            skidValid  <= 1'b0;
            skidInstr  <= 32'h0;
            skidPC     <= 32'h0;
            instrValid <= 1'b0;
            instr      <= 32'h0;
            instrPC    <= 32'h0;
        end else begin
            if (redirectValid) begin
                // Masking keeps the target word aligned while consuming every address bit.
                pcReg <= redirectAddr & 32'hFFFF_FFFC;
                pend  <= 1'b0;
            end else if (stall) begin
                pend <= 1'b0;
            end else begin
                pcReg  <= pcReg + PC_STEP;
                pend   <= 1'b1;
                pendPC <= pcReg;
            end

            if (squash) begin
                skidValid  <= 1'b0;
                state      <= RUN;
                instrValid <= 1'b0;
            end else if (stall) begin
                // The returning word must be kept, since its address will not be re-issued.
                if (pend && !skidValid) begin
                    skidValid <= 1'b1;
                    skidInstr <= iCacheReadData;
                    skidPC    <= pendPC;
                    state     <= HOLD;
                end
            end else if (state == HOLD) begin
                instr      <= skidInstr;
                instrPC    <= skidPC;
                instrValid <= 1'b1;
                skidValid  <= 1'b0;
                state      <= RUN;
            end else if (pend) begin
                instr      <= iCacheReadData;
                instrPC    <= pendPC;
                instrValid <= 1'b1;
            end else begin
                instrValid <= 1'b0;
            end
        end
    end

endmodule
